// File: rtl/alu_pkg.sv
// Shared ALU definitions: select encodings, R-type funct codes and the
// issue-unit state enum, used by the external ALU and the issue unit.
package alu_pkg;

   localparam logic [2:0] SEL_AND = 3'b000;
   localparam logic [2:0] SEL_OR  = 3'b001;
   localparam logic [2:0] SEL_ADD = 3'b010;
   localparam logic [2:0] SEL_NOP = 3'b011;
   localparam logic [2:0] SEL_NOR = 3'b100;
   localparam logic [2:0] SEL_XOR = 3'b101;
   localparam logic [2:0] SEL_SUB = 3'b110;
   localparam logic [2:0] SEL_SLT = 3'b111;

   localparam logic [5:0] OPC_RTYPE = 6'h00;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_XOR = 6'h26;
   localparam logic [5:0] FUNCT_NOR = 6'h27;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_funct_dec.sv
// Combinational R-type decode: opcode/funct to ALU select plus illegal flag.
// Anything that is not a mapped R-type operation becomes a NOP flagged illegal.
module alu_funct_dec
   import alu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] sel,
   output logic       illegal
);

   always_comb begin
      sel     = SEL_NOP;
      illegal = 1'b1;
      if (opcode == OPC_RTYPE) begin
         illegal = 1'b0;
         unique case (funct)
            FUNCT_AND: sel = SEL_AND;
            FUNCT_OR:  sel = SEL_OR;
            FUNCT_ADD: sel = SEL_ADD;
            FUNCT_SUB: sel = SEL_SUB;
            FUNCT_SLT: sel = SEL_SLT;
            FUNCT_NOR: sel = SEL_NOR;
            FUNCT_XOR: sel = SEL_XOR;
            default: begin
               sel     = SEL_NOP;
               illegal = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_unit.sv
// Single-issue front end for an external combinational ALU: accept one
// bundle, drive registered operands for one cycle, then hold the result.
module alu_issue_unit
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instValid,
   output logic        instReady,
   input  logic [31:0] instruction,
   input  logic [31:0] rsData,
   input  logic [31:0] rtData,
   output logic [2:0]  aluSel,
   output logic [31:0] aluOp1,
   output logic [31:0] aluOp2,
   input  logic [31:0] aluResult,
   output logic        resValid,
   input  logic        resReady,
   output logic [31:0] resData,
   output logic        resZero,
   output logic [4:0]  resRd,
   output logic        resWrite,
   output logic        resIllegal,
   output logic [15:0] opCount,
   output logic [15:0] illCount,
   output logic [1:0]  fsmState
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both 1; the result bundle holds steady while resValid waits on resReady.

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  sel_dec;
   logic        ill_dec;
   logic [4:0]  rd_q;
   logic        ill_q;
   logic [31:0] exec_data;
   logic        unused_fields;

   assign unused_fields = ^{instruction[25:16], instruction[10:6]};

   alu_funct_dec u_dec (
      .opcode  (instruction[31:26]),
      .funct   (instruction[5:0]),
      .sel     (sel_dec),
      .illegal (ill_dec)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (instValid) state_nxt = ST_EXEC;
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: if (resReady) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign instReady = (state == ST_IDLE);
   assign resValid  = (state == ST_RESP);
   assign fsmState  = state;

   // Illegal instructions never forward whatever the ALU makes of a NOP.
   assign exec_data = ill_q ? 32'd0 : aluResult;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aluSel     <= SEL_NOP;
         aluOp1     <= 32'd0;
         aluOp2     <= 32'd0;
         rd_q       <= 5'd0;
         ill_q      <= 1'b0;
         resData    <= 32'd0;
         resZero    <= 1'b0;
         resRd      <= 5'd0;
         resWrite   <= 1'b0;
         resIllegal <= 1'b0;
         opCount    <= 16'd0;
         illCount   <= 16'd0;
      end else begin
         if (state == ST_IDLE && instValid) begin
            aluSel <= sel_dec;
            aluOp1 <= rsData;
            aluOp2 <= rtData;
            rd_q   <= instruction[15:11];
            ill_q  <= ill_dec;
         end
         if (state == ST_EXEC) begin
            resData    <= exec_data;
            resZero    <= (exec_data == 32'd0);
            resRd      <= rd_q;
            resIllegal <= ill_q;
            resWrite   <= !ill_q && (rd_q != 5'd0);
            opCount    <= opCount + 16'd1;
            if (ill_q) illCount <= illCount + 16'd1;
         end
      end
   end

endmodule
